// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a one-entry registered output and valid/ready on every port.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise the lowest-index valid channel wins.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module arb_mux #(
   parameter  int LENGTH   = `WORD_LEN,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*LENGTH-1:0]   in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   output logic [LENGTH-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SEL_W-1:0]             out_sel
);

   logic [LENGTH-1:0] data_p1;
   logic [SEL_W-1:0]  sel_p1;
   logic              vld_p1;

   logic              can_load;
   logic              gnt_any;
   logic              xfer;
   logic [SEL_W-1:0]  win;
   logic [SEL_W-1:0]  idx;

`ifdef ARB_MUX_RR_EN
   logic [SEL_W-1:0]  ptr;

   // Channel k places after base, wrapped modulo CHANNELS (works for non-power-of-two counts).
   function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= CHANNELS) s = s - CHANNELS;
      return SEL_W'(s);
   endfunction
`endif

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      gnt_any = 1'b0;
      win     = '0;
      idx     = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
`ifdef ARB_MUX_RR_EN
         idx = rr_idx(ptr, k);
`else
         idx = SEL_W'(k);
`endif
         if (in_valid[idx]) begin
            gnt_any = 1'b1;
            win     = idx;
         end
      end
   end

   assign can_load = !vld_p1 || out_ready;
   // rst_n gates the grant so nothing is accepted while reset is held.
   assign xfer     = rst_n && gnt_any && can_load;
   assign in_ready = xfer ? (CHANNELS'(1) << win) : '0;

   // Stage p1: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= '0;
      end else if (xfer) begin
         vld_p1  <= 1'b1;
         data_p1 <= in_data[int'(win)*LENGTH +: LENGTH];
         sel_p1  <= win;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

`ifdef ARB_MUX_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer) begin
         if (win == SEL_W'(CHANNELS - 1)) ptr <= '0;
         else                             ptr <= win + SEL_W'(1);
      end
   end
`endif

   assign out_data  = data_p1;
   assign out_valid = vld_p1;
   assign out_sel   = sel_p1;

endmodule
